// File: rtl/monster_state_array.sv
// Per-monster behaviour controller: N_MON independent walkers with edge turn-around,
// hit-stun, hit points and death, advanced once per frame.
module monster_state_array #(
    parameter int N_MON      = 4,
    parameter int TURN_DELAY = 8,
    parameter int HIT_FRAMES = 16,
    parameter int HP_INIT    = 3,
    parameter int HP_W       = 2
) (
    input  logic                         frame_clk,
    input  logic                         Reset,
    input  logic                         freeze,
    input  logic [2*N_MON-1:0]           turn,
    input  logic [N_MON-1:0]             hit,
    input  logic [N_MON-1:0]             revive,
    output logic [N_MON-1:0]             dir,
    output logic [N_MON-1:0]             moving,
    output logic [N_MON-1:0]             alive,
    output logic [N_MON-1:0]             hurt,
    output logic [N_MON*HP_W-1:0]        hp,
    output logic [$clog2(N_MON+1)-1:0]   alive_count
);

    localparam int TMAX = (TURN_DELAY > HIT_FRAMES) ? TURN_DELAY : HIT_FRAMES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int CW   = $clog2(N_MON+1);

    typedef enum logic [1:0] {WALK, PAUSE, HIT, DEAD} mon_state_t;

    mon_state_t        state_q [N_MON];
    logic [TW-1:0]     timer_q [N_MON];
    logic [HP_W-1:0]   hp_q    [N_MON];
    logic [N_MON-1:0]  dir_q;
    logic [N_MON-1:0]  edge_match;
    logic [CW-1:0]     alive_cnt;

    // An edge only counts when it lies in the direction the monster is facing.
    always_comb begin
        edge_match = '0;
        for (int i = 0; i < N_MON; i++)
            edge_match[i] = dir_q[i] ? (turn[2*i +: 2] == 2'b10) : (turn[2*i +: 2] == 2'b01);
    end

    // NOTE: state updates use non-blocking assignments so every channel sees last frame's values.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            dir_q <= '0;
            for (int i = 0; i < N_MON; i++) begin
                state_q[i] <= WALK;
                timer_q[i] <= '0;
                hp_q[i]    <= HP_W'(HP_INIT);
            end
        end else if (!freeze) begin
            for (int i = 0; i < N_MON; i++) begin
                if (revive[i]) begin
                    state_q[i] <= WALK;
                    dir_q[i]   <= 1'b0;
                    timer_q[i] <= '0;
                    hp_q[i]    <= HP_W'(HP_INIT);
                end else begin
                    case (state_q[i])
                        WALK: begin
                            if (hit[i]) begin
                                if (hp_q[i] <= HP_W'(1)) begin
                                    hp_q[i]    <= '0;
                                    state_q[i] <= DEAD;
                                    timer_q[i] <= '0;
                                end else begin
                                    hp_q[i]    <= hp_q[i] - HP_W'(1);
                                    state_q[i] <= HIT;
                                    timer_q[i] <= TW'(HIT_FRAMES - 1);
                                end
                            end else if (edge_match[i]) begin
                                if (TURN_DELAY == 0) begin
                                    dir_q[i] <= ~dir_q[i];
                                end else begin
                                    state_q[i] <= PAUSE;
                                    timer_q[i] <= TW'(TURN_DELAY - 1);
                                end
                            end
                        end
                        PAUSE: begin
                            if (hit[i]) begin
                                // A hit mid-pause finishes the turn before the stun starts.
                                dir_q[i] <= ~dir_q[i];
                                if (hp_q[i] <= HP_W'(1)) begin
                                    hp_q[i]    <= '0;
                                    state_q[i] <= DEAD;
                                    timer_q[i] <= '0;
                                end else begin
                                    hp_q[i]    <= hp_q[i] - HP_W'(1);
                                    state_q[i] <= HIT;
                                    timer_q[i] <= TW'(HIT_FRAMES - 1);
                                end
                            end else if (timer_q[i] == '0) begin
                                dir_q[i]   <= ~dir_q[i];
                                state_q[i] <= WALK;
                            end else begin
                                timer_q[i] <= timer_q[i] - TW'(1);
                            end
                        end
                        HIT: begin
                            if (timer_q[i] == '0)
                                state_q[i] <= WALK;
                            else
                                timer_q[i] <= timer_q[i] - TW'(1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        dir       = dir_q;
        moving    = '0;
        alive     = '0;
        hurt      = '0;
        hp        = '0;
        alive_cnt = '0;
        for (int i = 0; i < N_MON; i++) begin
            moving[i]           = (state_q[i] == WALK);
            alive[i]            = (state_q[i] != DEAD);
            hurt[i]             = (state_q[i] == HIT);
            hp[HP_W*i +: HP_W]  = hp_q[i];
            alive_cnt           = alive_cnt + CW'(state_q[i] != DEAD);
        end
        alive_count = alive_cnt;
    end

endmodule

// File: tb/tb_monster_state_array.sv
// Randomised and directed bench for monster_state_array against a frame-counting reference model.
module tb_monster_state_array;

    localparam int N   = 4;
    localparam int TD  = 8;
    localparam int HF  = 16;
    localparam int HPI = 3;
    localparam int HW  = 2;

    logic            frame_clk = 1'b0;
    logic            Reset;
    logic            freeze;
    logic [2*N-1:0]  turn;
    logic [N-1:0]    hit, revive;
    logic [N-1:0]    dir, moving, alive, hurt;
    logic [N*HW-1:0] hp;
    logic [2:0]      alive_count;

    monster_state_array #(.N_MON(N), .TURN_DELAY(TD), .HIT_FRAMES(HF), .HP_INIT(HPI), .HP_W(HW)) dut (
        .frame_clk(frame_clk), .Reset(Reset), .freeze(freeze), .turn(turn), .hit(hit),
        .revive(revive), .dir(dir), .moving(moving), .alive(alive), .hurt(hurt),
        .hp(hp), .alive_count(alive_count)
    );

    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: frames remaining in pause / stun, rather than a state machine.
    int m_hp [N];
    int m_pause [N];
    int m_stun [N];
    bit m_dir [N];
    bit m_dead [N];

    task automatic model_reset_ch(input int i);
        m_hp[i] = HPI; m_pause[i] = 0; m_stun[i] = 0; m_dir[i] = 0; m_dead[i] = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) model_reset_ch(i);
    endtask

    task automatic model_step();
        if (freeze) return;
        for (int i = 0; i < N; i++) begin
            logic [1:0] code;
            code = turn[2*i +: 2];
            if (revive[i]) model_reset_ch(i);
            else if (m_dead[i]) ;
            else if (m_stun[i] > 0) m_stun[i]--;
            else if (hit[i]) begin
                if (m_pause[i] > 0) begin m_dir[i] = !m_dir[i]; m_pause[i] = 0; end
                if (m_hp[i] == 1) begin m_hp[i] = 0; m_dead[i] = 1; end
                else begin m_hp[i]--; m_stun[i] = HF; end
            end else if (m_pause[i] > 0) begin
                m_pause[i]--;
                if (m_pause[i] == 0) m_dir[i] = !m_dir[i];
            end else if ((!m_dir[i] && code == 2'b01) || (m_dir[i] && code == 2'b10)) begin
                if (TD == 0) m_dir[i] = !m_dir[i];
                else m_pause[i] = TD;
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        logic [N-1:0] e_dir, e_mov, e_alive, e_hurt;
        logic [N*HW-1:0] e_hp;
        int e_cnt;
        e_cnt = 0;
        for (int i = 0; i < N; i++) begin
            e_dir[i]         = m_dir[i];
            e_alive[i]       = !m_dead[i];
            e_hurt[i]        = !m_dead[i] && m_stun[i] > 0;
            e_mov[i]         = !m_dead[i] && m_stun[i] == 0 && m_pause[i] == 0;
            e_hp[HW*i +: HW] = HW'(m_hp[i]);
            e_cnt           += m_dead[i] ? 0 : 1;
        end
        check({ctx, ".dir"},    32'(dir),    32'(e_dir));
        check({ctx, ".moving"}, 32'(moving), 32'(e_mov));
        check({ctx, ".alive"},  32'(alive),  32'(e_alive));
        check({ctx, ".hurt"},   32'(hurt),   32'(e_hurt));
        check({ctx, ".hp"},     32'(hp),     32'(e_hp));
        check({ctx, ".count"},  32'(alive_count), 32'(e_cnt));
    endtask

    task automatic step(input string ctx, input logic fz, input logic [2*N-1:0] t,
                        input logic [N-1:0] h, input logic [N-1:0] r);
        freeze = fz; turn = t; hit = h; revive = r;
        @(posedge frame_clk);
        model_step();
        #1;
        compare_all(ctx);
    endtask

    task automatic idle(input string ctx, input int n);
        for (int k = 0; k < n; k++) step(ctx, 1'b0, '0, '0, '0);
    endtask

    initial begin
        int cnt;
        Reset = 1'b1; freeze = 1'b0; turn = '0; hit = '0; revive = '0;
        model_reset();
        repeat (2) @(posedge frame_clk);
        #4 Reset = 1'b0;
        compare_all("reset");

        idle("idle", 3);
        check("rst.hp_all3", 32'(hp), 32'hFF);
        check("rst.count4", 32'(alive_count), 32'd4);

        // ch0 turn-around pause
        step("turn0", 1'b0, 8'b0000_0001, '0, '0);
        cnt = 0;
        while (!moving[0] && cnt < 20) begin
            cnt++;
            step("pause0", 1'b0, '0, '0, '0);
        end
        check("pause_len", 32'(cnt), 32'd8);
        check("pause_dir", 32'(dir[0]), 32'd1);
        step("turn0_mismatch", 1'b0, 8'b0000_0001, '0, '0);
        check("mismatch_moving", 32'(moving[0]), 32'd1);

        // ch1 stun, invulnerable to a second hit
        step("hit1", 1'b0, '0, 4'b0010, '0);
        check("hit1.hp", 32'(hp[3:2]), 32'd2);
        idle("stun1", 5);
        step("hit1_again", 1'b0, '0, 4'b0010, '0);
        check("hit1_again.hp", 32'(hp[3:2]), 32'd2);
        idle("stun1_end", 12);
        check("stun1_over", 32'(moving[1]), 32'd1);

        // ch2 dies after three hits, then revives
        for (int k = 0; k < 3; k++) begin
            step("hit2", 1'b0, '0, 4'b0100, '0);
            idle("hit2_gap", 18);
        end
        check("dead2.alive", 32'(alive[2]), 32'd0);
        check("dead2.count", 32'(alive_count), 32'd3);
        step("dead2_ignore", 1'b0, 8'b0001_0000, 4'b0100, '0);
        step("revive2", 1'b0, '0, '0, 4'b0100);
        check("revive2.count", 32'(alive_count), 32'd4);

        // ch0 (facing left) hit in frame 4 of pause, then freeze mid-stun
        step("turn0_left", 1'b0, 8'b0000_0010, '0, '0);
        idle("pause0b", 3);
        step("hit_in_pause", 1'b0, '0, 4'b0001, '0);
        check("hit_in_pause.dir", 32'(dir[0]), 32'd0);
        check("hit_in_pause.hurt", 32'(hurt[0]), 32'd1);
        for (int k = 0; k < 10; k++) step("freeze", 1'b1, 8'hFF, 4'hF, 4'h0);
        idle("unfreeze", 8);

        // async reset between edges, mid-stun
        #2 Reset = 1'b1;
        model_reset();
        #1 compare_all("async_reset");
        check("async_reset.hurt", 32'(hurt), 32'd0);
        #1 Reset = 1'b0;
        step("rev_vs_hit", 1'b0, '0, 4'b1000, 4'b1000);
        check("rev_vs_hit.hurt", 32'(hurt[3]), 32'd0);

        // randomised phase
        for (int f = 0; f < 1500; f++) begin
            logic [N-1:0] h, r;
            for (int i = 0; i < N; i++) begin
                h[i] = ($urandom_range(0, 7) == 0);
                r[i] = ($urandom_range(0, 39) == 0);
            end
            if ($urandom_range(0, 299) == 0) begin
                #2 Reset = 1'b1;
                model_reset();
                #1 compare_all("rand_reset");
                #1 Reset = 1'b0;
            end
            step("rand", ($urandom_range(0, 9) == 0), (2*N)'($urandom), h, r);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/monster_state_array.md
Name: monster_state_array

Overview:
- Per-monster behaviour controller for N independent enemies, advanced once per frame on frame_clk.
- Each channel tracks the following, and sits between the edge/collision detection logic and the monster motion/sprite logic:
  - walking direction,
  - an optional turn-around pause,
  - a hit-stun window,
  - hit points,
  - death.
- Generalises the single-monster left/right walker with per-channel state, configurable timing and combat state.

Parameters:
- N_MON, 4, number of monster channels (1..16).
- TURN_DELAY, 8, frames a monster stands still at an edge before reversing; 0 = reverse on the same edge (no pause).
- HIT_FRAMES, 16, frames of stun after a non-lethal hit (>=1).
- HP_INIT, 3, hit points after reset/revive (1..2^HP_W-1).
- HP_W, 2, hit-point field width per channel.

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears every channel.
- freeze  in  1  game pause; when 1, all channels hold state, timers and hp.
- turn  in  2*N_MON  per-channel edge code, channel i at [2i+1:2i]: 01 = right edge hit, 10 = left edge hit, 00/11 = no edge.
- hit  in  N_MON  per-channel damage pulse (sampled level, one hit per frame max).
- revive  in  N_MON  per-channel reinitialise request.
- dir  out  N_MON  0 = facing right, 1 = facing left.
- moving  out  N_MON  1 when channel is in WALK state.
- alive  out  N_MON  0 only in DEAD.
- hurt  out  N_MON  1 in HIT state (sprite flash).
- hp  out  N_MON*HP_W  current hit points, channel i at [HP_W*i +: HP_W].
- alive_count  out  $clog2(N_MON+1)  popcount of alive, combinational from registered alive.

Behaviour:
- States per channel: WALK, PAUSE, HIT, DEAD; plus dir bit, hp register, shared-width down-counter timer (wide enough for max(TURN_DELAY,HIT_FRAMES)).
- Reset (async, any time, including mid-pause/mid-stun) gives every channel:
  - WALK, dir=0, hp=HP_INIT, timer=0;
  - outputs moving=1, alive=1, hurt=0, alive_count=N_MON.
- All outputs are registered state decodes; an input sampled at edge k is visible after edge k (1-frame latency).
- freeze=1: no channel changes (revive/hit/turn ignored), and timers do not count. Reset still overrides.
- Per-channel priority when not frozen: revive > hit > turn > timer expiry.
- revive (any state): WALK, dir=0, hp=HP_INIT, timer=0.
- WALK:
  - hit with hp>1: hp-=1, go to HIT, timer=HIT_FRAMES-1.
  - hit with hp==1: hp=0, go to DEAD.
  - Edge turn only when the edge matches the facing (dir=0 needs 01, dir=1 needs 10); mismatched codes, 00 and 11 are ignored.
  - On a matching edge with TURN_DELAY==0: dir flips, state stays WALK.
  - On a matching edge with TURN_DELAY>0: go to PAUSE, timer=TURN_DELAY-1, dir unchanged.
- PAUSE:
  - Timer decrements each frame.
  - At timer==0: dir flips, go to WALK.
  - turn input ignored.
  - A hit (same hp rules as WALK) completes the turn: dir flips immediately, then HIT or DEAD.
- HIT:
  - Invulnerable, so hit is ignored; turn is ignored.
  - Timer decrements; at timer==0 go to WALK with dir unchanged.
- DEAD: sticky; hit and turn ignored; only revive or Reset exit.
- Channels are fully independent; simultaneous events on different channels are all processed in the same frame.

Test Plan:
- Reset, then 3 frames idle, N_MON=4 -> dir=0000, moving=1111, alive=1111, hp all 3, alive_count=4.
- ch0 turn=01 for 1 frame, TURN_DELAY=8 -> moving[0]=0 for exactly 8 frames, then dir[0]=1, moving[0]=1; turn=01 again while dir=1 -> no change.
- ch1 hit pulse -> hp[1]=2, hurt[1]=1 for 16 frames; second hit during stun -> hp stays 2; after stun moving[1]=1, dir unchanged.
- ch2 three hits spaced >16 frames -> hp 3,2,1 then alive[2]=0, alive_count=3; turn and hit are then ignored; revive -> hp=3, dir=0, alive_count=4.
- ch0 hit at frame 4 of a PAUSE -> dir[0] flips that frame and hurt[0]=1; freeze=1 for 10 frames mid-stun -> timer and outputs hold, stun resumes after release.
- Reset asserted mid-stun and asynchronously between clock edges -> all outputs return to reset values immediately; revive and hit on the same frame -> revive wins (hp=HP_INIT, hurt=0).
